// File: rtl/mem_ctrl_if.sv
// Byte-wide memory bus bundle shared by the ifetch unit, the load/store
// buffer data port and the external RAM/IO port. The master modport is
// the memory controller; the slave modport is everything around it.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  // Instruction-fetch request/response
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  // Load/store buffer data request/response
  logic              d_wating;
  logic              d_wr;
  logic [2:0]        d_len;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_value;
  logic              d_done;
  logic [31:0]       d_result;

  // External byte-wide RAM/IO port
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport master (
    input  if_valid, if_addr, d_wating, d_wr, d_len, d_addr, d_value,
           mem_din, io_buffer_full,
    output if_done, if_data, d_done, d_result, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_valid, if_addr, d_wating, d_wr, d_len, d_addr, d_value,
           mem_din, io_buffer_full,
    input  if_done, if_data, d_done, d_result, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates the single byte-wide RAM/IO port between
// instruction fetch and the LSB data port, sequences 1/2/4-byte accesses
// one byte per cycle, assembles little-endian read data with sign/zero
// extension and returns it with a one-cycle done pulse.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear,
  mem_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_len;
  logic              r_sext;
  logic              r_is_if;
  logic              r_io;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [23:0]       r_buf;
  logic              r_if_done;
  logic              r_d_done;
  logic [31:0]       r_if_data;
  logic [31:0]       r_d_result;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;

  logic [2:0]        w_d_n;
  logic              w_d_io;
  logic [2:0]        w_rd_next;
  logic [2:0]        w_wr_idx;
  logic [1:0]        w_cap_idx;
  logic              w_fill;
  logic [31:0]       w_rd_word;

  // Byte count of an access from the low two length bits
  function automatic logic [2:0] lenToCount(input logic [1:0] len);
    case (len)
      2'b00:   lenToCount = 3'd1;
      2'b01:   lenToCount = 3'd2;
      default: lenToCount = 3'd4;
    endcase
  endfunction

  // Little-endian byte lane select of a store word
  function automatic logic [7:0] pickByte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    pickByte = word[7:0];
      2'd1:    pickByte = word[15:8];
      2'd2:    pickByte = word[23:16];
      default: pickByte = word[31:24];
    endcase
  endfunction

  assign w_d_n     = lenToCount(bus.d_len[1:0]);
  assign w_d_io    = (bus.d_addr[17:16] == IO_HI);
  assign w_rd_next = r_cnt + 3'd1;
  // A write index only advances once its byte has actually been written
  assign w_wr_idx  = r_mem_wr ? (r_cnt + 3'd1) : r_cnt;
  // The byte landing on mem_din now was addressed two steps ago
  assign w_cap_idx = r_cnt[1:0] - 2'd1;
  assign w_fill    = r_sext & bus.mem_din[7];

  // Final read word: earlier bytes from the buffer, last byte straight off mem_din, extended
  always_comb begin
    w_rd_word = {bus.mem_din, r_buf};
    case (r_len)
      3'd1:    w_rd_word = {{24{w_fill}}, bus.mem_din};
      3'd2:    w_rd_word = {{16{w_fill}}, bus.mem_din, r_buf[7:0]};
      default: w_rd_word = {bus.mem_din, r_buf};
    endcase
  end

  // Main sequencer: arbitration, byte stepping, read assembly, stall, flush and done pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_sext     <= 1'b0;
      r_is_if    <= 1'b0;
      r_io       <= 1'b0;
      r_base     <= '0;
      r_wdata    <= 32'd0;
      r_buf      <= 24'd0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_if_data  <= 32'd0;
      r_d_result <= 32'd0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
    end else if (rdy_in) begin
      unique case (r_state)
        IDLE: begin
          r_if_done <= 1'b0;
          r_d_done  <= 1'b0;
          r_cnt     <= 3'd0;
          if (!clear && bus.d_wating) begin
            r_is_if <= 1'b0;
            r_base  <= bus.d_addr;
            r_len   <= w_d_n;
            r_sext  <= bus.d_len[2];
            r_wdata <= bus.d_value;
            r_io    <= w_d_io;
            r_mem_a <= bus.d_addr;
            if (bus.d_wr) begin
              r_state    <= WR;
              r_mem_dout <= bus.d_value[7:0];
              r_mem_wr   <= !(w_d_io && bus.io_buffer_full);
            end else begin
              r_state  <= RD;
              r_mem_wr <= 1'b0;
            end
          end else if (!clear && bus.if_valid) begin
            r_is_if  <= 1'b1;
            r_base   <= bus.if_addr;
            r_len    <= 3'd4;
            r_sext   <= 1'b0;
            r_io     <= 1'b0;
            r_mem_a  <= bus.if_addr;
            r_mem_wr <= 1'b0;
            r_state  <= RD;
          end
        end
        RD: begin
          if (clear) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_mem_wr <= 1'b0;
          end else if (r_cnt == r_len) begin
            if (r_is_if) begin
              r_if_done <= 1'b1;
              r_if_data <= w_rd_word;
            end else begin
              r_d_done   <= 1'b1;
              r_d_result <= w_rd_word;
            end
            r_state <= DONE;
          end else begin
            if (w_rd_next < r_len) begin
              r_mem_a <= r_base + ADDR_W'(w_rd_next);
            end
            if (r_cnt != 3'd0) begin
              case (w_cap_idx)
                2'd0:    r_buf[7:0]   <= bus.mem_din;
                2'd1:    r_buf[15:8]  <= bus.mem_din;
                default: r_buf[23:16] <= bus.mem_din;
              endcase
            end
            r_cnt <= w_rd_next;
          end
        end
        WR: begin
          if (w_wr_idx == r_len) begin
            r_mem_wr <= 1'b0;
            r_d_done <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt      <= w_wr_idx;
            r_mem_a    <= r_base + ADDR_W'(w_wr_idx);
            r_mem_dout <= pickByte(r_wdata, w_wr_idx[1:0]);
            r_mem_wr   <= !(r_io && bus.io_buffer_full);
          end
        end
        DONE: begin
          r_if_done <= 1'b0;
          r_d_done  <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;
  assign bus.d_done   = r_d_done;
  assign bus.d_result = r_d_result;
  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  // A frozen controller must never leave a write strobe asserted
  assign bus.mem_wr   = r_mem_wr & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, fetch/load/store sequences,
// arbitration, IO back-pressure, flush, global stall and async reset.
module tb_mem_ctrl;

  logic clk;
  logic rstN;
  logic rdy;
  logic clr;
  int   errors;
  int   checks;
  logic [7:0]  ram [0:4095];
  logic [31:0] swVal;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in (clk),
    .rst_in (rstN),
    .rdy_in (rdy),
    .clear  (clr),
    .bus    (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // One-cycle-latency byte RAM; IO addresses alias onto low RAM
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[11:0]];
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request just after a falling edge; return in cycle 1 after acceptance
  task automatic applyStimulus(input logic isFetch, input logic wr, input logic [2:0] len,
                               input logic [31:0] addr, input logic [31:0] value);
    if (isFetch) begin
      bus.if_valid = 1'b1;
      bus.if_addr  = addr;
    end else begin
      bus.d_wating = 1'b1;
      bus.d_wr     = wr;
      bus.d_len    = len;
      bus.d_addr   = addr;
      bus.d_value  = value;
    end
    @(posedge clk);
    @(negedge clk);
    if (isFetch) bus.if_valid = 1'b0;
    else bus.d_wating = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rstN = 1'b0;
    rdy = 1'b1;
    clr = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_addr = 32'd0;
    bus.d_wating = 1'b0;
    bus.d_wr = 1'b0;
    bus.d_len = 3'd0;
    bus.d_addr = 32'd0;
    bus.d_value = 32'd0;
    bus.io_buffer_full = 1'b0;
    bus.mem_din = 8'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'd0;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h78; ram[12'h201] = 8'h56; ram[12'h202] = 8'h34; ram[12'h203] = 8'h12;
    ram[12'h300] = 8'h80;
    ram[12'h310] = 8'h34; ram[12'h311] = 8'hF2;

    // Reset values
    #2;
    checkOutput("rst_if_done", 32'(bus.if_done), 32'd0);
    checkOutput("rst_d_done", 32'(bus.d_done), 32'd0);
    checkOutput("rst_if_data", bus.if_data, 32'd0);
    checkOutput("rst_d_result", bus.d_result, 32'd0);
    checkOutput("rst_mem_a", bus.mem_a, 32'd0);
    checkOutput("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    checkOutput("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Word fetch at 0x100
    $display("[TB] ifetch 0x100");
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h100, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 4) checkOutput("if_mem_a", bus.mem_a, 32'h100 + 32'(c) - 32'd1);
      checkOutput("if_mem_wr", 32'(bus.mem_wr), 32'd0);
      checkOutput("if_done_timing", 32'(bus.if_done), 32'(c == 6));
    end
    checkOutput("if_data", bus.if_data, 32'h00000513);
    checkOutput("if_no_d_done", 32'(bus.d_done), 32'd0);
    @(negedge clk);

    // Simultaneous requests: data wins, fetch follows after an idle cycle
    $display("[TB] arbitration");
    bus.if_valid = 1'b1;
    bus.if_addr = 32'h100;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h200, 32'd0);
    checkOutput("arb_data_first", bus.mem_a, 32'h200);
    repeat (5) @(negedge clk);
    checkOutput("arb_d_done", 32'(bus.d_done), 32'd1);
    checkOutput("arb_lw", bus.d_result, 32'h12345678);
    checkOutput("arb_no_if_done", 32'(bus.if_done), 32'd0);
    @(negedge clk);
    checkOutput("arb_idle_d_done", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    checkOutput("arb_if_accept", bus.mem_a, 32'h100);
    bus.if_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("arb_if_done", 32'(bus.if_done), 32'd1);
    @(negedge clk);

    // Byte and half loads with and without sign extension
    $display("[TB] lb / lbu / lh");
    applyStimulus(1'b0, 1'b0, 3'b100, 32'h300, 32'd0);
    @(negedge clk);
    checkOutput("lb_early", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    checkOutput("lb_done", 32'(bus.d_done), 32'd1);
    checkOutput("lb_result", bus.d_result, 32'hFFFFFF80);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h300, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("lbu_done", 32'(bus.d_done), 32'd1);
    checkOutput("lbu_result", bus.d_result, 32'h00000080);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b101, 32'h310, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("lh_early", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    checkOutput("lh_done", 32'(bus.d_done), 32'd1);
    checkOutput("lh_result", bus.d_result, 32'hFFFFF234);
    @(negedge clk);

    // Word store, then read it back
    $display("[TB] sw 0xDEADBEEF");
    swVal = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h400, swVal);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      checkOutput("sw_mem_wr", 32'(bus.mem_wr), 32'd1);
      checkOutput("sw_mem_a", bus.mem_a, 32'h400 + 32'(c) - 32'd1);
      checkOutput("sw_mem_dout", 32'(bus.mem_dout), 32'(swVal[8*(c-1) +: 8]));
      checkOutput("sw_no_done", 32'(bus.d_done), 32'd0);
    end
    @(negedge clk);
    checkOutput("sw_done", 32'(bus.d_done), 32'd1);
    checkOutput("sw_wr_off", 32'(bus.mem_wr), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h400, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("sw_readback", bus.d_result, 32'hDEADBEEF);
    @(negedge clk);

    // IO byte store under back-pressure
    $display("[TB] IO stall");
    bus.io_buffer_full = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h30000, 32'h000000A5);
    checkOutput("io_stall1", 32'(bus.mem_wr), 32'd0);
    @(negedge clk);
    checkOutput("io_stall2", 32'(bus.mem_wr), 32'd0);
    @(negedge clk);
    checkOutput("io_stall3", 32'(bus.mem_wr), 32'd0);
    checkOutput("io_no_done", 32'(bus.d_done), 32'd0);
    bus.io_buffer_full = 1'b0;
    @(negedge clk);
    checkOutput("io_write", 32'(bus.mem_wr), 32'd1);
    checkOutput("io_dout", 32'(bus.mem_dout), 32'h000000A5);
    checkOutput("io_addr", bus.mem_a, 32'h00030000);
    @(negedge clk);
    checkOutput("io_done", 32'(bus.d_done), 32'd1);
    @(negedge clk);

    // Flush during fetch: no if_done, block free the next cycle
    $display("[TB] flush ifetch");
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h100, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("flush_if_none", 32'(bus.if_done), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b100, 32'h300, 32'd0);
    checkOutput("flush_idle_next", bus.mem_a, 32'h300);
    @(negedge clk);
    checkOutput("flush_if_none2", 32'(bus.if_done), 32'd0);
    @(negedge clk);
    checkOutput("flush_lb_done", 32'(bus.d_done), 32'd1);
    checkOutput("flush_lb_result", bus.d_result, 32'hFFFFFF80);
    checkOutput("flush_if_none3", 32'(bus.if_done), 32'd0);
    @(negedge clk);

    // Flush during store: write still completes
    $display("[TB] flush sw");
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h400, 32'h11223344);
    checkOutput("fsw_wr1", 32'(bus.mem_wr), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    checkOutput("fsw_wr2", 32'(bus.mem_wr), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    checkOutput("fsw_wr3", 32'(bus.mem_wr), 32'd1);
    @(negedge clk);
    checkOutput("fsw_wr4", 32'(bus.mem_dout), 32'h00000011);
    @(negedge clk);
    checkOutput("fsw_done", 32'(bus.d_done), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h400, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("fsw_readback", bus.d_result, 32'h11223344);
    @(negedge clk);

    // Global stall freezes the sequencer for two cycles
    $display("[TB] rdy stall");
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h300, 32'd0);
    rdy = 1'b0;
    checkOutput("rdy_mem_a", bus.mem_a, 32'h300);
    @(negedge clk);
    checkOutput("rdy_hold1", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    rdy = 1'b1;
    checkOutput("rdy_hold2", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    checkOutput("rdy_hold3", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    checkOutput("rdy_done", 32'(bus.d_done), 32'd1);
    checkOutput("rdy_result", bus.d_result, 32'h00000080);
    @(negedge clk);

    // Asynchronous reset in the middle of a word read
    $display("[TB] reset mid-read");
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h200, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("arst_mem_a", bus.mem_a, 32'd0);
    checkOutput("arst_d_result", bus.d_result, 32'd0);
    checkOutput("arst_if_data", bus.if_data, 32'd0);
    checkOutput("arst_mem_dout", 32'(bus.mem_dout), 32'd0);
    checkOutput("arst_d_done", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("arst_no_done", 32'(bus.d_done | bus.if_done), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide RAM/IO port between the instruction-fetch unit and the load/store buffer data port, and sequences multi-byte accesses one byte per cycle.
- Sits between the ifetch/LSB and the top-level memory bus.
- Assembles little-endian read data with sign/zero extension, returns it with a one-cycle done pulse, and handles IO back-pressure and pipeline flush.

Parameters:
- ADDR_W, 32, address width.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; the block holds all state while low
- clear  in  1  flush from RoB on misprediction
- if_valid  in  1  instruction-fetch request
- if_addr  in  32  fetch address (4-byte read)
- if_done  out  1  one-cycle pulse: fetched word valid
- if_data  out  32  fetched word
- d_wating  in  1  LSB data request
- d_wr  in  1  1 = store
- d_len  in  3  [1:0]: 00 byte, 01 half, 10 word; [2]: sign-extend load
- d_addr  in  32  data address
- d_value  in  32  store data, low bytes used
- d_done  out  1  one-cycle pulse: data access complete
- d_result  out  32  load result, extended
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO write back-pressure

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; if_done = d_done = 0; if_data = d_result = 0; mem_a = 0; mem_dout = 0; mem_wr = 0; byte counter 0. Reset asserted mid-access abandons the access and produces no done pulse.
- States: IDLE, RD, WR, DONE. All outputs are registered.
- Arbitration in IDLE:
  - If d_wating is high, the data request wins; the ifetch request waits.
  - Otherwise, if if_valid is high, the ifetch request is served.
  - A request is accepted at the edge where it wins; its address and length are latched, so inputs may change afterwards.
  - Once accepted, an access runs to completion or flush without preemption.
- Access length N: 1, 2 or 4 bytes from d_len[1:0]; ifetch is always N = 4. No alignment check; byte addresses are base + i.
- Read (RD):
  - Cycles 1..N after acceptance drive mem_a = base + i, mem_wr = 0.
  - RAM latency is one cycle: the byte for address i is on mem_din in cycle i+2 and lands in bits [8i+7:8i].
  - DONE occupies cycle N+2: the target done pulse is high with data valid, then the block returns to IDLE.
  - Word read: accepted at edge 0, done high in cycle 6.
- Extension: for half/byte loads with d_len[2] = 1, the top bit of the last byte fills the upper bits; with d_len[2] = 0 the upper bits are zero-filled.
- Write (WR):
  - Cycles 1..N drive mem_a = base + i, mem_wr = 1, mem_dout = d_value[8i+7:8i].
  - d_done is high in cycle N+1; d_result is undefined-but-stable (held) on writes.
- IO stall: if addr[17:16] == IO_HI and io_buffer_full is high, mem_wr is forced 0 and the byte index holds until io_buffer_full drops. IO reads are not stalled.
- Flush (clear high):
  - An ifetch or a data read in progress is abandoned: next state IDLE, no done pulse, mem_wr = 0.
  - A data write in progress always completes and still pulses d_done.
  - In IDLE with clear high, no request is accepted that cycle.
- rdy_in low: state, counters and outputs are frozen except mem_wr, which is forced 0; pending done pulses are held until rdy_in returns.
- Only one done pulse exists per accepted access; if_done and d_done are never high together.
- After DONE, the block takes at least one IDLE cycle before accepting the next request, so the turnaround is fixed.

Test Plan:
- Ifetch at 0x100, RAM bytes 13 05 00 00 -> if_done in cycle 6 after acceptance, if_data = 0x00000513; mem_a steps 0x100..0x103.
- if_valid and d_wating (lw 0x200) raised together -> data served first, d_done; then ifetch accepted in a later IDLE cycle.
- lb at 0x300 byte 0x80 with d_len = 100 -> d_result = 0xFFFFFF80; same access with lbu (000) -> 0x00000080; lh at bytes 34 F2 -> 0xFFFFF234.
- sw 0xDEADBEEF at 0x400 -> mem_wr high for 4 cycles, mem_dout EF BE AD DE, d_done in cycle 5.
- sb to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write; d_done delayed by 3 cycles.
- clear in cycle 2 of an ifetch -> no if_done, IDLE next cycle; clear during an sw -> write completes and d_done pulses; rst_in low mid-read -> all outputs return to 0 immediately.
